// File: rtl/alu_pkg.sv
// Shared opcode encodings and arbiter pointer states for the ALU arbiter slice.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic {
    RR_LAST0 = 1'b0,
    RR_LAST1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU: (op, a, b) -> (result, zero, err).
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_zero,
  output logic         o_err
);

  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {{(W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_err    = 1'b1;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a registered
// response slot per port that can be drained and refilled on the same edge.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][3:0]       req_op,
  input  logic [1:0][W-1:0]     req_a,
  input  logic [1:0][W-1:0]     req_b,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [1:0][W-1:0]     rsp_result,
  output logic [1:0]            rsp_zero,
  output logic [1:0]            rsp_err,
  output logic [1:0][TAG_W-1:0] rsp_tag
);

  rr_ptr_e              r_rr_ptr;
  rr_ptr_e              w_rr_next;
  logic [1:0]           w_elig;
  logic [1:0]           w_gnt;
  logic                 w_sel;
  logic [W-1:0]         w_result;
  logic                 w_zero;
  logic                 w_err;

  logic [1:0]           r_rsp_valid;
  logic [1:0][W-1:0]    r_rsp_result;
  logic [1:0]           r_rsp_zero;
  logic [1:0]           r_rsp_err;
  logic [1:0][TAG_W-1:0] r_rsp_tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rr_ptr <= RR_LAST1;
    else      r_rr_ptr <= w_rr_next;
  end

  // A full response slot only blocks its port if it is not being drained now.
  always_comb begin
    w_elig    = req_valid & (~r_rsp_valid | rsp_ready);
    w_gnt     = 2'b00;
    w_rr_next = r_rr_ptr;
    if (rst) begin
      if (w_elig == 2'b11) w_gnt = (r_rr_ptr == RR_LAST0) ? 2'b10 : 2'b01;
      else                 w_gnt = w_elig;
    end
    if (w_gnt[0])      w_rr_next = RR_LAST0;
    else if (w_gnt[1]) w_rr_next = RR_LAST1;
  end

  assign req_ready = w_gnt;
  assign w_sel     = w_gnt[1];

  alu_core #(.W(W)) u_alu_core (
    .i_op     (req_op[w_sel]),
    .i_a      (req_a[w_sel]),
    .i_b      (req_b[w_sel]),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_err    (w_err)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rsp_valid[gi]  <= 1'b0;
        r_rsp_result[gi] <= '0;
        r_rsp_zero[gi]   <= 1'b0;
        r_rsp_err[gi]    <= 1'b0;
        r_rsp_tag[gi]    <= '0;
      end else if (w_gnt[gi]) begin
        r_rsp_valid[gi]  <= 1'b1;
        r_rsp_result[gi] <= w_result;
        r_rsp_zero[gi]   <= w_zero;
        r_rsp_err[gi]    <= w_err;
        r_rsp_tag[gi]    <= req_tag[gi];
      end else if (rsp_ready[gi]) begin
        r_rsp_valid[gi]  <= 1'b0;
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign rsp_tag    = r_rsp_tag;

endmodule
